rr_grant_arbiter: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 30 +++
 rtl/grant_onehot.sv | 15 +
 rtl/rr_grant_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Holds the requester constants, the FSM state enum and the rotating winner search.
package rr_arb_pkg;

    localparam int unsigned NREQ  = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req scanning ptr+1, ptr+2, ... wrapping; ptr itself is visited last.
    function automatic rr_pick_t next_rr(input logic [NREQ-1:0] req, input logic [IDX_W-1:0] ptr);
        rr_pick_t         pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grant_onehot.sv
// Combinational 3-to-8 decode of a grant index, gated by its valid flag.
module grant_onehot
    import rr_arb_pkg::*;
(
    input  logic             vld,
    input  logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (vld) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with registered index/valid/one-hot grant outputs.
// Optional forced-release hold timeout is built when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arb_en,
    input  logic [NREQ-1:0]  req,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [NREQ-1:0]  gnt,
    output logic             timeout
);

    if (NREQ != 8 || IDX_W != 3) begin : g_bad_width
        $error("rr_grant_arbiter supports only NREQ=8, IDX_W=3");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_grant_arbiter HOLD_MAX must be in 2..255");
    end

    state_t           state, nxt_state;
    logic [IDX_W-1:0] ptr, nxt_ptr, nxt_idx;
    logic             nxt_vld;
    logic [NREQ-1:0]  nxt_gnt;
    rr_pick_t         pick;

    assign pick = next_rr(req, ptr);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt, nxt_cnt;
    logic       nxt_timeout;
    rr_pick_t   pick_other;

    // ptr equals the holder while granted, so masking it leaves the rotation order intact.
    assign pick_other = next_rr(req & ~gnt, ptr);
`endif

    always_comb begin
        nxt_state = state;
        nxt_vld   = gnt_vld;
        nxt_idx   = gnt_idx;
        nxt_ptr   = ptr;
`ifdef ARB_TIMEOUT_EN
        nxt_cnt     = hold_cnt;
        nxt_timeout = 1'b0;
`endif
        if (!arb_en) begin
            nxt_state = IDLE;
            nxt_vld   = 1'b0;
            nxt_idx   = '0;
        end else if (state == IDLE || !req[gnt_idx]) begin
            if (pick.found) begin
                nxt_state = GRANT;
                nxt_vld   = 1'b1;
                nxt_idx   = pick.idx;
                nxt_ptr   = pick.idx;
`ifdef ARB_TIMEOUT_EN
                nxt_cnt   = '0;
`endif
            end else begin
                nxt_state = IDLE;
                nxt_vld   = 1'b0;
                nxt_idx   = '0;
            end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
            if (pick_other.found) begin
                nxt_idx     = pick_other.idx;
                nxt_ptr     = pick_other.idx;
                nxt_cnt     = '0;
                nxt_timeout = 1'b1;
            end
        end else begin
            nxt_cnt = hold_cnt + 8'd1;
        end
`endif
    end

    grant_onehot u_onehot (
        .vld    (nxt_vld),
        .idx    (nxt_idx),
        .onehot (nxt_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
            gnt     <= '0;
            ptr     <= '1;
        end else begin
            state   <= nxt_state;
            gnt_vld <= nxt_vld;
            gnt_idx <= nxt_idx;
            gnt     <= nxt_gnt;
            ptr     <= nxt_ptr;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= nxt_cnt;
            timeout  <= nxt_timeout;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: vector table plus reset and timeout sequences.
// Define ARB_TIMEOUT_EN on both bench and RTL to exercise the hold timeout.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arb_en = 1'b0;
    logic [7:0] req = 8'h00;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       vld;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[$];

    rr_grant_arbiter #(.NREQ(8), .IDX_W(3), .HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (arb_en),
        .req     (req),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt     (gnt),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] onehot(input logic vld, input logic [2:0] idx);
        logic [7:0] one;
        one = 8'h01;
        return vld ? (one << idx) : 8'h00;
    endfunction

    task automatic check_out(input string tag, input logic vld, input logic [2:0] idx,
                             input logic tmo);
        check({tag, ".vld"}, 32'(gnt_vld), 32'(vld));
        check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, ".gnt"}, 32'(gnt), 32'(onehot(vld, idx)));
        check({tag, ".timeout"}, 32'(timeout), 32'(tmo));
    endtask

    task automatic add(input logic en, input logic [7:0] r, input logic vld, input logic [2:0] idx);
        vec_t v;
        v.en = en; v.req = r; v.vld = vld; v.idx = idx;
        vecs.push_back(v);
    endtask

    task automatic step(input logic en, input logic [7:0] r);
        arb_en = en;
        req    = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] r;
        // Basic grant from reset, ptr starts at 7 so requester 0 wins first.
        add(1, 8'h01, 1, 0);
        add(1, 8'hFF, 1, 0);
        // Full rotation: each holder keeps req for two cycles, then drops it.
        for (int k = 1; k < 8; k++) begin
            r = 8'hFF & ~(8'h01 << (k - 1));
            add(1, r, 1, 3'(k));
            add(1, r, 1, 3'(k));
        end
        add(1, 8'h7F, 1, 0);
        // Wrap from 7 to 0, then on to 3.
        add(1, 8'h80, 1, 7);
        add(1, 8'h09, 1, 0);
        add(1, 8'h08, 1, 3);
        add(1, 8'h08, 1, 3);
        // arb_en low clears the grant, ptr retained at 3.
        add(0, 8'h08, 0, 0);
        add(1, 8'h04, 1, 2);
        // Release with nothing pending returns to idle.
        add(1, 8'h00, 0, 0);
        // From idle with ptr=2: 3..7,0 empty, 1 wins; non-granted drop is ignored.
        add(1, 8'h06, 1, 1);
        add(1, 8'h02, 1, 1);
        add(1, 8'h00, 0, 0);
        add(0, 8'hFF, 0, 0);

        #1;
        check_out("reset_state", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_out("idle_after_reset", 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].req);
            check_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].idx, 0);
        end

        // Asynchronous reset between edges clears outputs and ptr.
        step(1, 8'h02);
        check_out("pre_reset_grant", 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0);
        #1;
        rst_n = 1'b1;
        // ptr=7 picks 1 first; a retained ptr=1 would pick 7.
        step(1, 8'h82);
        check_out("ptr_reset", 1, 1, 0);
        step(1, 8'h80);
        check_out("after_reset_80", 1, 7, 0);
        step(1, 8'h00);
        check_out("back_idle", 0, 0, 0);

`ifdef ARB_TIMEOUT_EN
        // HOLD_MAX=4: contended grants swap every 4 cycles with a timeout pulse.
        for (int k = 0; k < 16; k++) begin
            step(1, 8'h03);
            check_out($sformatf("tmo_alt%0d", k), 1, 3'((k / 4) % 2), (k > 0) && (k % 4 == 0));
        end
        for (int k = 0; k < 12; k++) begin
            step(1, 8'h01);
            check_out($sformatf("tmo_hold%0d", k), 1, 0, 0);
        end
`else
        for (int k = 0; k < 8; k++) begin
            step(1, 8'h03);
            check_out($sformatf("no_tmo%0d", k), 1, 0, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
